// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one i2c_master between P_NUM_REQ requesters on i_local_clk.
// Define I2C_ARB_BUSY_TIMEOUT_EN to add a watchdog on the master's busy assertion.
module i2c_master_arbiter #(
    parameter int P_NUM_REQ = 2,
    parameter int P_LEN_W   = 9,
    parameter int P_BUSY_TO = 16
) (
    input  logic                           i_local_clk,
    input  logic                           i_rst_n,
    input  logic [P_NUM_REQ-1:0]           i_req,
    input  logic [8*P_NUM_REQ-1:0]         i_req_dev_addr,
    input  logic [P_LEN_W*P_NUM_REQ-1:0]   i_req_num,
    input  logic [8*P_NUM_REQ-1:0]         i_req_reg_addr,
    input  logic [8*P_NUM_REQ-1:0]         i_req_wr_data,
    output logic [P_NUM_REQ-1:0]           o_gnt,
    output logic [P_NUM_REQ-1:0]           o_wr_done,
    output logic [P_NUM_REQ-1:0]           o_rd_valid,
    output logic [7:0]                     o_rd_data,
    output logic [P_NUM_REQ-1:0]           o_done,
    output logic [P_NUM_REQ-1:0]           o_err,
    output logic                           o_m_start,
    output logic [7:0]                     o_m_device_addr,
    output logic [P_LEN_W-1:0]             o_m_req_num,
    output logic [7:0]                     o_m_reg_addr,
    output logic [7:0]                     o_m_wr_data,
    input  logic                           i_m_busy,
    input  logic                           i_m_wr_done,
    input  logic                           i_m_rd_valid,
    input  logic [7:0]                     i_m_rd_data,
    input  logic                           i_m_ack_erro,
    input  logic                           i_m_erro_valid
);

    localparam int IDX_W = $clog2(P_NUM_REQ);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_RUN       = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [7:0]         dev_addr_q, dev_addr_d;
    logic [P_LEN_W-1:0] req_num_q, req_num_d;
    logic               err_q, err_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [7:0]         win_dev_addr;
    logic [P_LEN_W-1:0] win_req_num;
    logic               gnt_active;
    logic               err_hit;
    logic               to_expired;

    assign err_hit    = i_m_erro_valid & i_m_ack_erro;
    assign gnt_active = (state_q == S_START) || (state_q == S_WAIT_BUSY) ||
                        (state_q == S_RUN)   || (state_q == S_DONE);

`ifdef I2C_ARB_BUSY_TIMEOUT_EN
    localparam int TO_W = $clog2(P_BUSY_TO + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    // Counts idle WAIT_BUSY cycles; expires on the P_BUSY_TO-th one.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == S_WAIT_BUSY && !i_m_busy) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_local_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    assign to_expired = (to_cnt_q == TO_W'(P_BUSY_TO - 1));
`else
    assign to_expired = 1'b0;
`endif

    // Winner: first requester at or after the rr pointer, wrapping modulo P_NUM_REQ.
    always_comb begin
        win_found    = 1'b0;
        win_idx      = '0;
        win_dev_addr = '0;
        win_req_num  = '0;
        for (int off = 0; off < P_NUM_REQ; off++) begin
            for (int k = 0; k < P_NUM_REQ; k++) begin
                if (!win_found && i_req[k] &&
                    ((int'(rr_q) + off == k) || (int'(rr_q) + off == k + P_NUM_REQ))) begin
                    win_found    = 1'b1;
                    win_idx      = IDX_W'(k);
                    win_dev_addr = i_req_dev_addr[8*k +: 8];
                    win_req_num  = i_req_num[P_LEN_W*k +: P_LEN_W];
                end
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        rr_d       = rr_q;
        dev_addr_d = dev_addr_q;
        req_num_d  = req_num_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (win_found && !i_m_busy) begin
                    state_d    = S_START;
                    gnt_idx_d  = win_idx;
                    dev_addr_d = win_dev_addr;
                    req_num_d  = win_req_num;
                    err_d      = 1'b0;
                end
            end
            S_START: state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (err_hit) err_d = 1'b1;
                if (i_m_busy) begin
                    state_d = S_RUN;
                end else if (to_expired) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_RUN: begin
                if (err_hit) err_d = 1'b1;
                if (!i_m_busy) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                rr_d    = (gnt_idx_q == IDX_W'(P_NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_local_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            gnt_idx_q  <= '0;
            rr_q       <= '0;
            dev_addr_q <= '0;
            req_num_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            rr_q       <= rr_d;
            dev_addr_q <= dev_addr_d;
            req_num_q  <= req_num_d;
            err_q      <= err_d;
        end
    end

    // Per-requester routing; everything is gated by the held grant so idle requesters see zeros.
    always_comb begin
        o_gnt        = '0;
        o_wr_done    = '0;
        o_rd_valid   = '0;
        o_done       = '0;
        o_err        = '0;
        o_m_reg_addr = '0;
        o_m_wr_data  = '0;
        for (int k = 0; k < P_NUM_REQ; k++) begin
            if (gnt_active && (gnt_idx_q == IDX_W'(k))) begin
                o_gnt[k]      = 1'b1;
                o_wr_done[k]  = i_m_wr_done;
                o_rd_valid[k] = i_m_rd_valid;
                o_done[k]     = (state_q == S_DONE);
                o_err[k]      = (state_q == S_DONE) && err_q;
                o_m_reg_addr  = i_req_reg_addr[8*k +: 8];
                o_m_wr_data   = i_req_wr_data[8*k +: 8];
            end
        end
    end

    assign o_m_start       = (state_q == S_START);
    assign o_m_device_addr = dev_addr_q;
    assign o_m_req_num     = req_num_q;
    assign o_rd_data       = i_m_rd_data;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: table of transactions plus timeout and reset sequences.
// Honours I2C_ARB_BUSY_TIMEOUT_EN when defined for the build.
module tb_i2c_master_arbiter;

    localparam int N     = 2;
    localparam int LEN_W = 9;
    localparam int TO    = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [N-1:0]       i_req = '0;
    logic [8*N-1:0]     i_req_dev_addr = 16'h53A0;
    logic [LEN_W*N-1:0] i_req_num = {9'd3, 9'd256};
    logic [8*N-1:0]     i_req_reg_addr = 16'h2110;
    logic [8*N-1:0]     i_req_wr_data = 16'hB1B0;
    logic [N-1:0]       o_gnt, o_wr_done, o_rd_valid, o_done, o_err;
    logic [7:0]         o_rd_data;
    logic               o_m_start;
    logic [7:0]         o_m_device_addr, o_m_reg_addr, o_m_wr_data;
    logic [LEN_W-1:0]   o_m_req_num;
    logic               i_m_busy = 1'b0;
    logic               i_m_wr_done = 1'b0;
    logic               i_m_rd_valid = 1'b0;
    logic [7:0]         i_m_rd_data = 8'h5A;
    logic               i_m_ack_erro = 1'b0;
    logic               i_m_erro_valid = 1'b0;

    logic [7:0]       dev_c [2] = '{8'hA0, 8'h53};
    logic [LEN_W-1:0] num_c [2] = '{9'd256, 9'd3};
    logic [7:0]       reg_c [2] = '{8'h10, 8'h21};
    logic [7:0]       wd_c  [2] = '{8'hB0, 8'hB1};

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    i2c_master_arbiter #(.P_NUM_REQ(N), .P_LEN_W(LEN_W), .P_BUSY_TO(TO)) dut (
        .i_local_clk     (clk),
        .i_rst_n         (rst_n),
        .i_req           (i_req),
        .i_req_dev_addr  (i_req_dev_addr),
        .i_req_num       (i_req_num),
        .i_req_reg_addr  (i_req_reg_addr),
        .i_req_wr_data   (i_req_wr_data),
        .o_gnt           (o_gnt),
        .o_wr_done       (o_wr_done),
        .o_rd_valid      (o_rd_valid),
        .o_rd_data       (o_rd_data),
        .o_done          (o_done),
        .o_err           (o_err),
        .o_m_start       (o_m_start),
        .o_m_device_addr (o_m_device_addr),
        .o_m_req_num     (o_m_req_num),
        .o_m_reg_addr    (o_m_reg_addr),
        .o_m_wr_data     (o_m_wr_data),
        .i_m_busy        (i_m_busy),
        .i_m_wr_done     (i_m_wr_done),
        .i_m_rd_valid    (i_m_rd_valid),
        .i_m_rd_data     (i_m_rd_data),
        .i_m_ack_erro    (i_m_ack_erro),
        .i_m_erro_valid  (i_m_erro_valid)
    );

    typedef struct {
        logic [N-1:0] req;
        int           exp_idx;
        int           busy_cyc;
        int           n_rd;
        bit           inj_err;
        bit           exp_err;
        bit           drop_mid;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits (bounded) for o_m_start; returns on the negedge where it is seen.
    task automatic wait_start(output bit found);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (o_m_start) found = 1'b1;
        end
        check("start_seen", 32'(found), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        bit           found;
        bit           held_ok;
        int           rd0, rd1, pulses;
        logic [N-1:0] exp_gnt;
        exp_gnt = N'(1 << v.exp_idx);
        i_req   = v.req;
        wait_start(found);
        if (!found) return;
        check("gnt", 32'(o_gnt), 32'(exp_gnt));
        check("dev_addr", 32'(o_m_device_addr), 32'(dev_c[v.exp_idx]));
        check("req_num", 32'(o_m_req_num), 32'(num_c[v.exp_idx]));
        check("reg_mux", 32'(o_m_reg_addr), 32'(reg_c[v.exp_idx]));
        check("wr_mux", 32'(o_m_wr_data), 32'(wd_c[v.exp_idx]));
        check("rd_data", 32'(o_rd_data), 32'h5A);
        @(negedge clk);
        check("start_1cyc", 32'(o_m_start), 32'd0);
        if (v.drop_mid) i_req = '0;
        i_m_busy    = 1'b1;
        i_m_wr_done = 1'b1;
        #1;
        check("wr_done_route", 32'(o_wr_done), 32'(exp_gnt));
        held_ok = 1'b1;
        rd0 = 0;
        rd1 = 0;
        pulses = 0;
        for (int c = 0; c < v.busy_cyc; c++) begin
            @(negedge clk);
            i_m_wr_done    = 1'b0;
            i_m_rd_valid   = (c % 2 == 1) && (pulses < v.n_rd);
            if (i_m_rd_valid) pulses++;
            i_m_erro_valid = v.inj_err && (c == v.busy_cyc / 2);
            i_m_ack_erro   = i_m_erro_valid;
            #1;
            rd0 += int'(o_rd_valid[0]);
            rd1 += int'(o_rd_valid[1]);
            if (o_gnt !== exp_gnt || o_done !== '0 || o_err !== '0) held_ok = 1'b0;
        end
        check("gnt_held", 32'(held_ok), 32'd1);
        check("rd_cnt_granted", 32'(v.exp_idx == 0 ? rd0 : rd1), 32'(v.n_rd));
        check("rd_cnt_other", 32'(v.exp_idx == 0 ? rd1 : rd0), 32'd0);
        @(negedge clk);
        i_m_busy       = 1'b0;
        i_m_rd_valid   = 1'b0;
        i_m_erro_valid = 1'b0;
        i_m_ack_erro   = 1'b0;
        @(negedge clk);
        check("done", 32'(o_done), 32'(exp_gnt));
        check("err", 32'(o_err), v.exp_err ? 32'(exp_gnt) : 32'd0);
        check("gnt_in_done", 32'(o_gnt), 32'(exp_gnt));
        @(negedge clk);
        check("gnt_idle", 32'(o_gnt), 32'd0);
        check("done_1cyc", 32'(o_done), 32'd0);
        check("reg_mux_idle", 32'(o_m_reg_addr), 32'd0);
        check("dev_addr_stable", 32'(o_m_device_addr), 32'(dev_c[v.exp_idx]));
    endtask

    initial begin
        bit found;
        bit no_done;
        int lat;

        //          req    idx busy  n_rd inj   exp   drop
        vecs[0] = '{2'b01, 0, 1000,   0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{2'b11, 1,  600, 256, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{2'b11, 0,    6,   0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{2'b11, 1,    6,   0, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{2'b11, 0,    6,   0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{2'b01, 0,    6,   0, 1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_gnt", 32'(o_gnt), 32'd0);
        check("rst_start", 32'(o_m_start), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_dev", 32'(o_m_device_addr), 32'd0);
        check("rst_num", 32'(o_m_req_num), 32'd0);
        check("rst_reg", 32'(o_m_reg_addr), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Master never raises busy.
        i_req = 2'b01;
        wait_start(found);
        @(negedge clk);
`ifdef I2C_ARB_BUSY_TIMEOUT_EN
        lat = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            if (o_done != '0) begin
                lat = c;
                check("to_err", 32'(o_err), 32'h1);
                check("to_done", 32'(o_done), 32'h1);
            end
        end
        check("to_latency", 32'(lat), 32'(TO));
        wait_start(found);
        @(negedge clk);
`else
        no_done = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_done != '0) no_done = 1'b0;
        end
        check("no_timeout_done", 32'(no_done), 32'd1);
        check("wait_gnt_held", 32'(o_gnt), 32'h1);
`endif

        // Reset while the master is running; rr pointer sits at 1 here.
        i_m_busy = 1'b1;
        repeat (3) @(negedge clk);
        i_req = 2'b11;
        rst_n = 1'b0;
        #1;
        check("arst_gnt", 32'(o_gnt), 32'd0);
        check("arst_start", 32'(o_m_start), 32'd0);
        check("arst_done", 32'(o_done), 32'd0);
        check("arst_dev", 32'(o_m_device_addr), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        i_m_busy = 1'b0;
        wait_start(found);
        check("post_rst_gnt", 32'(o_gnt), 32'h1);
        check("post_rst_dev", 32'(o_m_device_addr), 32'hA0);
        @(negedge clk);
        i_m_busy = 1'b1;
        repeat (4) @(negedge clk);
        i_m_busy = 1'b0;
        i_req    = 2'b00;
        @(negedge clk);
        check("post_rst_done", 32'(o_done), 32'h1);
        check("post_rst_err", 32'(o_err), 32'd0);
        repeat (3) @(negedge clk);
        check("final_idle", 32'(o_gnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
